mem_responder: RTL
==================

# mem_responder

Memory-side responder for the multicycle CPU's data/instruction bus. It accepts one read or write request at a time, models a fixed access latency, and performs sub-word writes by byte-lane merging into a word-organised array. It returns a single-cycle acknowledge with the full addressed word. It sits between the CPU's address/write-data muxes and the storage, replacing a zero-wait memory when latency-tolerant control is exercised.

## Interface
- `DEPTH_WORDS`, 256 — number of 32-bit words stored; word index = `addr[31:2]`.
- `LATENCY`, 2 — cycles from request acceptance to `ack`; legal range 1..15.
- `clock`  in  1  — single clock, rising edge.
- `reset`  in  1  — synchronous, active-high; one clock, reset synchronous active-high.
- `req`  in  1  — request valid; sampled only in IDLE.
- `wr`  in  1  — 1 = write, 0 = read; captured with `req`.
- `size`  in  2  — access size: 00 word, 01 halfword, 10 byte, 11 reserved (treated as word).
- `addr`  in  32  — byte address.
- `wdata`  in  32  — write data; sub-word data taken from low bits (`wdata[15:0]` / `wdata[7:0]`).
- `rdata`  out  32  — full addressed word, valid only while `ack`=1, else 0.
- `ack`  out  1  — one-cycle completion pulse.
- `busy`  out  1  — high from acceptance until and including the `ack` cycle.
- `err`  out  1  — qualifies `ack`: request faulted, no write performed, `rdata`=0.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: if `req`, capture `wr`, `size`, `addr`, `wdata`; load counter with `LATENCY-1`; go to WAIT (or straight to RESP when `LATENCY`=1).
- WAIT: decrement the counter each cycle; at 0, go to RESP.
- RESP: assert `ack` for one cycle; perform the write this cycle; drive `rdata` with the pre-write word contents for reads; return to IDLE.
- `req` is ignored in WAIT and RESP, with no queueing. The requester must wait for `ack`.
- Byte order is big-endian: byte offset 0 maps to bits [31:24].
  - Halfword offset 0 maps to [31:16]; offset 2 maps to [15:0].
  - Untouched lanes keep their prior value.
- Out of range: word index ≥ `DEPTH_WORDS` gives `ack`=1, `err`=1, no write, `rdata`=0.
- Storage contents are not cleared by `reset`. The power-up contents of the array are don't-care.

## Timing
- Reset values: state IDLE, `ack`=0, `busy`=0, `err`=0, `rdata`=0, counter 0.
- Latency: `req` sampled high at edge N gives `ack` high during cycle N+`LATENCY`.
- Minimum request spacing is `LATENCY`+1 cycles. `req` is re-sampled in the cycle after `ack`.
- `reset` mid-transaction: the access is abandoned, no write occurs, and no `ack` is issued. Outputs are at reset values on the next cycle.
- `req` coincident with `reset`: reset wins and the request is dropped.

## Configuration
- `MEM_MISALIGN_TRAP_EN` defined:
  - a halfword with `addr[0]`=1 responds `ack`+`err` with no write;
  - a word with `addr[1:0]`≠0 responds `ack`+`err` with no write.
- Without it, the offending low address bits are ignored: a halfword aligns down to a 2-byte boundary, a word aligns down to a 4-byte boundary, and `err` only reports out-of-range.

## Structure
- Shared package holds:
  - size encodings (`SIZE_WORD`, `SIZE_HALF`, `SIZE_BYTE`);
  - the state enum (IDLE/WAIT/RESP);
  - a function mapping (`size`, `addr[1:0]`) to a 4-bit byte-lane mask.
- Sub-module `mem_word_array`: `DEPTH_WORDS`×32 storage with asynchronous read and a synchronous write using the byte-lane mask.
- Top level holds the FSM, counter, request capture, range/alignment checks, and write-data lane replication.

## Test plan
- Word write then read, `LATENCY`=2:
  - write 0xDEADBEEF at 0x10; `ack` exactly 2 cycles after `req`, `err`=0;
  - a read of 0x10 returns 0xDEADBEEF on `ack`, and `rdata`=0 on the other cycles.
- Byte merge: word 0x11223344 at 0x20, then byte write `wdata`=0xAA at 0x21; reading 0x20 gives 0x11AA3344.
- Halfword merge: from 0x11223344, halfword 0xBEEF at 0x22 gives 0x1122BEEF.
- Out of range and ignored requests:
  - read at byte address 4×`DEPTH_WORDS` gives `ack`=1, `err`=1, `rdata`=0, and array contents are unchanged;
  - `req` pulses during WAIT produce no extra `ack`.
- Reset mid-operation: write accepted, then `reset` asserted in the WAIT cycle; no `ack` occurs and a later read returns the old word.
- Misalignment:
  - with `MEM_MISALIGN_TRAP_EN`, a word write at 0x13 gives `err`=1 and no change;
  - without the macro, the same write lands at 0x10.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared types for mem_responder: access size codes, FSM states and the
// big-endian byte-lane mask helper (bit 3 of the mask selects data[31:24]).
package mem_responder_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Reserved size 2'b11 falls through to a full-word mask.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] m;
    case (size)
      SIZE_HALF: m = off[1] ? 4'b0011 : 4'b1100;
      SIZE_BYTE: m = 4'b1000 >> off;
      default:   m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between the CPU-side requester and mem_responder.
interface mem_responder_if;
  import mem_responder_pkg::*;

  logic              req;
  logic              wr;
  logic [1:0]        size;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;
  logic              busy;
  logic              err;

  modport master (output req, wr, size, addr, wdata, input rdata, ack, busy, err);
  modport slave  (input req, wr, size, addr, wdata, output rdata, ack, busy, err);
endinterface

// File: rtl/mem_word_array.sv
// Word-organised storage: asynchronous read, synchronous byte-lane-masked write.
module mem_word_array
  import mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic              clock,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clock) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder with big-endian sub-word merging.
// Optional MEM_MISALIGN_TRAP_EN turns misaligned half/word accesses into err responses.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic           clock,
  input  logic           reset,
  mem_responder_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_e            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              capture_c;

  logic              wr_q;
  logic [1:0]        size_q;
  logic [1:0]        off_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic              fault_q;

  logic              range_err_c, misalign_c, fault_c, fault_sel_c;
  logic [IDX_W-1:0]  idx_c;
  logic [3:0]        be_c;
  logic [DATA_W-1:0] wdata_rep_c, word_c;
  logic              we_c;

  logic              ack_nx, err_nx;
  logic [DATA_W-1:0] rdata_nx;
  logic              ack_q, busy_q, err_q;
  logic [DATA_W-1:0] rdata_q;

  assign range_err_c = {2'b00, bus.addr[31:2]} >= 32'(DEPTH_WORDS);

  always_comb begin
    misalign_c = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    case (bus.size)
      SIZE_HALF: misalign_c = bus.addr[0];
      SIZE_BYTE: misalign_c = 1'b0;
      default:   misalign_c = (bus.addr[1:0] != 2'b00);
    endcase
`else
    misalign_c = 1'b0;
`endif
  end

  assign fault_c = range_err_c | misalign_c;

  // Next state and counter; capture_c marks the accepting IDLE cycle.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    capture_c = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req) begin
          capture_c = 1'b1;
          cnt_nx    = CNT_LOAD;
          state_nx  = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_nx = cnt - CNT_W'(1);
        if (cnt <= CNT_W'(1)) state_nx = RESP;
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // With LATENCY=1 the response is formed from the live bus, not the capture regs.
  assign idx_c       = capture_c ? bus.addr[IDX_W+1:2] : idx_q;
  assign fault_sel_c = capture_c ? fault_c : fault_q;

  always_comb begin
    ack_nx   = (state_nx == RESP);
    err_nx   = 1'b0;
    rdata_nx = '0;
    if (ack_nx) begin
      err_nx   = fault_sel_c;
      rdata_nx = fault_sel_c ? '0 : word_c;
    end
  end

  always_comb begin
    case (size_q)
      SIZE_HALF: wdata_rep_c = {2{wdata_q[15:0]}};
      SIZE_BYTE: wdata_rep_c = {4{wdata_q[7:0]}};
      default:   wdata_rep_c = wdata_q;
    endcase
  end

  assign be_c = lane_mask(size_q, off_q);
  assign we_c = (state == RESP) && wr_q && !fault_q && !reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      wr_q    <= 1'b0;
      size_q  <= SIZE_WORD;
      off_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      ack_q   <= ack_nx;
      busy_q  <= (state_nx != IDLE);
      err_q   <= err_nx;
      rdata_q <= rdata_nx;
      if (capture_c) begin
        wr_q    <= bus.wr;
        size_q  <= bus.size;
        off_q   <= bus.addr[1:0];
        idx_q   <= bus.addr[IDX_W+1:2];
        wdata_q <= bus.wdata;
        fault_q <= fault_c;
      end
    end
  end

  mem_word_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clock (clock),
    .we    (we_c),
    .be    (be_c),
    .idx   (idx_c),
    .wdata (wdata_rep_c),
    .rdata (word_c)
  );

  assign bus.ack   = ack_q;
  assign bus.busy  = busy_q;
  assign bus.err   = err_q;
  assign bus.rdata = rdata_q;

endmodule
